serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It time-shares one combinational 1-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. A start/busy/done handshake sequences the operation. It is the smallest-area add path for blocks that tolerate a latency of WIDTH cycles.

---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/serial_add_ctrl_bit_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared encodings and defaults for the bit-serial adder controller.
package serial_add_ctrl_pkg;

   localparam int ADD_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_bit_adder.sv
// Single-bit full adder cell, time-shared by the serial add controller.
module bit_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first.
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | waiting for start; operands captured on start
// ST_RUN  | one result bit per edge, WIDTH edges total
// ST_DONE | result published, done pulsed for one cycle
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   // Holds the WIDTH-1 bits already produced; the last bit joins on the final edge.
   logic [WIDTH-2:0] s_sr_q, s_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             s_bit;
   logic             c_bit;
   logic [WIDTH-1:0] s_ext;

   bit_adder u_bit_adder (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .s    (s_bit),
      .cout (c_bit)
   );

   assign s_ext = {s_bit, s_sr_q};

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               a_sr_d  = a_in;
               b_sr_d  = b_in;
               carry_d = cin_in;
               cnt_d   = '0;
               s_sr_d  = '0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            s_sr_d  = s_ext[WIDTH-1:1];
            carry_d = c_bit;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               sum_d   = s_ext;
               cout_d  = c_bit;
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for the bit-serial adder controller (WIDTH=8).
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       cin_in;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   int vectors = 0;
   int miscompares = 0;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a_in   (a_in),
      .b_in   (b_in),
      .cin_in (cin_in),
      .busy   (busy),
      .done   (done),
      .sum    (sum),
      .cout   (cout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one add and follows it to its done pulse, reporting observations only.
   task automatic issue_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                           output int busy_cycles, output bit done_seen,
                           output bit early_change);
      logic [7:0] prev_sum;
      logic       prev_cout;
      busy_cycles  = 0;
      done_seen    = 1'b0;
      early_change = 1'b0;
      prev_sum     = sum;
      prev_cout    = cout;
      a_in   = a;
      b_in   = b;
      cin_in = c;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            done_seen = 1'b1;
            break;
         end
         if (busy) busy_cycles++;
         if (sum !== prev_sum || cout !== prev_cout) early_change = 1'b1;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a_in = 8'h05; b_in = 8'h03; cin_in = 1'b1;
      tick();
      tick();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
      vectors++;
      if (sum !== 8'h00) begin miscompares++; $display("FAIL reset_sum: got %h expected 00", sum); end
      vectors++;
      if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b expected 0", cout); end
      rst = 1'b0; start = 1'b0;
      tick();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_no_start: busy got %b expected 0", busy); end
   endtask

   task automatic test_basic();
      int bc; bit ds; bit ec;
      issue_op(8'h05, 8'h03, 1'b0, bc, ds, ec);
      vectors++;
      if (ds !== 1'b1) begin miscompares++; $display("FAIL basic_done_seen: got %b expected 1", ds); end
      vectors++;
      if (bc != 8) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
      vectors++;
      if (ec !== 1'b0) begin miscompares++; $display("FAIL basic_partial_result: got %b expected 0", ec); end
      vectors++;
      if (sum !== 8'h08) begin miscompares++; $display("FAIL basic_sum: got %h expected 08", sum); end
      vectors++;
      if (cout !== 1'b0) begin miscompares++; $display("FAIL basic_cout: got %b expected 0", cout); end
      tick();
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width: got %b expected 0", done); end
      tick();
   endtask

   task automatic test_carry();
      int bc; bit ds; bit ec;
      issue_op(8'hFF, 8'h01, 1'b0, bc, ds, ec);
      vectors++;
      if (ds !== 1'b1) begin miscompares++; $display("FAIL ripple1_done_seen: got %b expected 1", ds); end
      vectors++;
      if (sum !== 8'h00) begin miscompares++; $display("FAIL ripple1_sum: got %h expected 00", sum); end
      vectors++;
      if (cout !== 1'b1) begin miscompares++; $display("FAIL ripple1_cout: got %b expected 1", cout); end
      tick();
      tick();
      issue_op(8'hFF, 8'hFF, 1'b1, bc, ds, ec);
      vectors++;
      if (ds !== 1'b1) begin miscompares++; $display("FAIL ripple2_done_seen: got %b expected 1", ds); end
      vectors++;
      if (ec !== 1'b0) begin miscompares++; $display("FAIL ripple2_partial_result: got %b expected 0", ec); end
      vectors++;
      if (sum !== 8'hFF) begin miscompares++; $display("FAIL ripple2_sum: got %h expected ff", sum); end
      vectors++;
      if (cout !== 1'b1) begin miscompares++; $display("FAIL ripple2_cout: got %b expected 1", cout); end
      tick();
      tick();
   endtask

   task automatic test_start_while_busy();
      int pulses;
      logic [7:0] got_sum;
      logic       got_cout;
      pulses = 0; got_sum = 8'h00; got_cout = 1'b0;
      a_in = 8'hA5; b_in = 8'h5A; cin_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1; a_in = 8'h01; b_in = 8'h01; cin_in = 1'b1;
      tick();
      start = 1'b0; a_in = 8'hFF;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            pulses++;
            got_sum  = sum;
            got_cout = cout;
         end
         tick();
      end
      vectors++;
      if (pulses != 1) begin miscompares++; $display("FAIL busy_ignore_pulses: got %0d expected 1", pulses); end
      vectors++;
      if (got_sum !== 8'hFF) begin miscompares++; $display("FAIL busy_ignore_sum: got %h expected ff", got_sum); end
      vectors++;
      if (got_cout !== 1'b0) begin miscompares++; $display("FAIL busy_ignore_cout: got %b expected 0", got_cout); end
      vectors++;
      if (sum !== 8'hFF) begin miscompares++; $display("FAIL busy_ignore_hold: got %h expected ff", sum); end
   endtask

   task automatic test_continuous();
      int pulses;
      int last;
      int first;
      pulses = 0; last = -1; first = -1;
      a_in = 8'h10; b_in = 8'h20; cin_in = 1'b0; start = 1'b1;
      tick();
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (done) begin
            pulses++;
            vectors++;
            if (sum !== 8'h30) begin miscompares++; $display("FAIL continuous_sum: got %h expected 30 at cycle %0d", sum, c); end
            if (last >= 0) begin
               vectors++;
               if (c - last != 10) begin miscompares++; $display("FAIL continuous_interval: got %0d expected 10", c - last); end
            end else begin
               first = c;
            end
            last = c;
         end
      end
      vectors++;
      if (pulses != 3) begin miscompares++; $display("FAIL continuous_pulses: got %0d expected 3", pulses); end
      vectors++;
      if (first != 8) begin miscompares++; $display("FAIL continuous_first_done: got %0d expected 8", first); end
      start = 1'b0;
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_reset_mid();
      int pulses;
      int bc; bit ds; bit ec;
      pulses = 0;
      a_in = 8'h33; b_in = 8'h11; cin_in = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b expected 0", done); end
      vectors++;
      if (sum !== 8'h00) begin miscompares++; $display("FAIL midreset_sum: got %h expected 00", sum); end
      vectors++;
      if (cout !== 1'b0) begin miscompares++; $display("FAIL midreset_cout: got %b expected 0", cout); end
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) pulses++;
         tick();
      end
      vectors++;
      if (pulses != 0) begin miscompares++; $display("FAIL midreset_abandon: activity cycles got %0d expected 0", pulses); end
      issue_op(8'h7F, 8'h01, 1'b0, bc, ds, ec);
      vectors++;
      if (ds !== 1'b1) begin miscompares++; $display("FAIL after_reset_done_seen: got %b expected 1", ds); end
      vectors++;
      if (sum !== 8'h80) begin miscompares++; $display("FAIL after_reset_sum: got %h expected 80", sum); end
      vectors++;
      if (cout !== 1'b0) begin miscompares++; $display("FAIL after_reset_cout: got %b expected 0", cout); end
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00; cin_in = 1'b0;
      test_reset();
      test_basic();
      test_carry();
      test_start_while_busy();
      test_continuous();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
